// File: rtl/inference_sequencer_if.sv
// inference_sequencer_if: input/result streams plus the weight-memory address and layer-datapath
// controls of the inference sequencer; master is the sequencer, slave is the surrounding datapath.
interface inference_sequencer_if #(
   parameter int LAYER_DEPTH = 4,
   parameter int BIT_SIZE    = 16
);
   localparam int AW = (LAYER_DEPTH > 1) ? $clog2(LAYER_DEPTH) : 1;
   logic                x_valid;
   logic                x_ready;
   logic [BIT_SIZE-1:0] x_data;
   logic [AW-1:0]       mem_layer;
   logic                layer_clr;
   logic                input_select;
   logic [BIT_SIZE-1:0] x_out;
   logic [BIT_SIZE-1:0] y_in;
   logic                y_valid;
   logic                y_ready;
   logic [BIT_SIZE-1:0] y_data;
   logic                busy;
   modport master (
      input  x_valid, x_data, y_in, y_ready,
      output x_ready, mem_layer, layer_clr, input_select, x_out, y_valid, y_data, busy
   );
   modport slave (
      output x_valid, x_data, y_in, y_ready,
      input  x_ready, mem_layer, layer_clr, input_select, x_out, y_valid, y_data, busy
   );
endinterface

// File: rtl/inference_sequencer.sv
// inference_sequencer: loads one input vector, walks it through LAYER_DEPTH stored layers
// (clear, serial feed, drain per layer) and streams the final layer outputs back out.
module inference_sequencer #(
   parameter int LAYER_SIZE  = 4,
   parameter int LAYER_DEPTH = 4,
   parameter int BIT_SIZE    = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   inference_sequencer_if.master  bus
);
   localparam int KW = (LAYER_SIZE > 1) ? $clog2(LAYER_SIZE) : 1;
   localparam int AW = (LAYER_DEPTH > 1) ? $clog2(LAYER_DEPTH) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(LAYER_SIZE - 1);
   localparam logic [AW-1:0] L_LAST = AW'(LAYER_DEPTH - 1);
   typedef enum logic [2:0] {IDLE, LOAD, CLEAR, FEED, DRAIN, EMIT} state_t;
   state_t              r_state, w_next;
   logic [KW-1:0]       r_k, w_k, w_k_inc;
   logic [AW-1:0]       r_layer, w_layer;
   logic [BIT_SIZE-1:0] r_buf [LAYER_SIZE];
   logic                r_x_ready, r_layer_clr, r_input_select, r_y_valid, r_busy;
   logic [BIT_SIZE-1:0] r_x_out, w_x_out;
   logic                w_last_k, w_last_layer, w_x_hs, w_y_hs;
   assign w_last_k     = r_k == K_LAST;
   assign w_last_layer = r_layer == L_LAST;
   assign w_k_inc      = w_last_k ? '0 : r_k + 1'b1;
   assign w_x_hs       = r_x_ready & bus.x_valid;
   assign w_y_hs       = r_y_valid & bus.y_ready;
   // The buffer is not written in FEED, so the next word can be looked up one cycle early.
   assign w_x_out      = (w_next == FEED) ? r_buf[w_k] : '0;
   always_comb begin
      w_next  = r_state;
      w_k     = r_k;
      w_layer = r_layer;
      case (r_state)
         IDLE, LOAD: if (w_x_hs) begin
            w_next  = w_last_k ? CLEAR : LOAD;
            w_k     = w_k_inc;
            w_layer = '0;
         end
         CLEAR: w_next = FEED;
         FEED: begin
            w_next = w_last_k ? DRAIN : FEED;
            w_k    = w_k_inc;
         end
         DRAIN: begin
            w_next  = !w_last_k ? DRAIN : w_last_layer ? EMIT : CLEAR;
            w_k     = w_k_inc;
            w_layer = (w_last_k && !w_last_layer) ? r_layer + 1'b1 : r_layer;
         end
         EMIT: if (w_y_hs) begin
            w_next  = w_last_k ? IDLE : EMIT;
            w_k     = w_k_inc;
            w_layer = w_last_k ? '0 : r_layer;
         end
         default: w_next = IDLE;
      endcase
   end
   // Control outputs are registered from the next state so they line up with the state itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_k            <= '0;
         r_layer        <= '0;
         r_x_ready      <= 1'b0;
         r_layer_clr    <= 1'b0;
         r_input_select <= 1'b1;
         r_x_out        <= '0;
         r_y_valid      <= 1'b0;
         r_busy         <= 1'b0;
         for (int i = 0; i < LAYER_SIZE; i++) r_buf[i] <= '0;
      end else begin
         r_state        <= w_next;
         r_k            <= w_k;
         r_layer        <= w_layer;
         r_x_ready      <= (w_next == IDLE) || (w_next == LOAD);
         r_layer_clr    <= w_next == CLEAR;
         r_input_select <= w_next != DRAIN;
         r_x_out        <= w_x_out;
         r_y_valid      <= w_next == EMIT;
         r_busy         <= w_next != IDLE;
         if (w_x_hs) r_buf[r_k] <= bus.x_data;
         else if (r_state == DRAIN) r_buf[r_k] <= bus.y_in;
      end
   end
   assign bus.x_ready      = r_x_ready;
   assign bus.mem_layer    = r_layer;
   assign bus.layer_clr    = r_layer_clr;
   assign bus.input_select = r_input_select;
   assign bus.x_out        = r_x_out;
   assign bus.y_valid      = r_y_valid;
   assign bus.busy         = r_busy;
   assign bus.y_data       = (r_state == EMIT) ? r_buf[r_k] : '0;
endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer: drives random and directed inferences through a layer stub and
// compares the feed sequence, addressing and results against a vector-level reference model.
module tb_inference_sequencer;
   typedef logic [3:0][15:0] vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0, n_err = 0, cyc = 0, h_cyc = 0;
   bit   mode = 1'b0, mon_en = 1'b0;
   logic [15:0] off = '0;
   logic [15:0] fed [4];
   logic [1:0]  fcnt = '0, dcnt = '0;
   logic        w_feed;
   logic [15:0] feed_q[$];
   logic [1:0]  feedl_q[$], clr_q[$], drl_q[$];
   inference_sequencer_if #(.LAYER_DEPTH(4), .BIT_SIZE(16)) bus();
   inference_sequencer #(.LAYER_SIZE(4), .LAYER_DEPTH(4), .BIT_SIZE(16)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign w_feed = bus.busy & bus.input_select & ~bus.layer_clr & ~bus.x_ready & ~bus.y_valid;
   // Layer stub: mode 0 returns {layer, word} nibbles plus an offset; mode 1 mixes the fed words.
   always @(posedge clk) begin
      dcnt <= bus.input_select ? 2'd0 : dcnt + 2'd1;
      fcnt <= w_feed ? fcnt + 2'd1 : 2'd0;
      if (w_feed) fed[fcnt] <= bus.x_out;
   end
   always_comb begin
      bus.y_in = mode ? (fed[dcnt + 2'd1] ^ (16'h1111 * {14'd0, bus.mem_layer})) + {14'd0, dcnt}
                      : off + {10'd0, bus.mem_layer, 2'b00, dcnt};
   end
   always @(negedge clk) if (mon_en && rst_n) begin
      if (bus.layer_clr) clr_q.push_back(bus.mem_layer);
      if (w_feed) begin
         feed_q.push_back(bus.x_out);
         feedl_q.push_back(bus.mem_layer);
      end
      if (!bus.input_select) drl_q.push_back(bus.mem_layer);
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic vec_t layer_fn(input vec_t v, input int l);
      vec_t r;
      for (int j = 0; j < 4; j++)
         r[j] = mode ? (v[(j + 1) % 4] ^ 16'(16'h1111 * l)) + 16'(j) : off + 16'(l * 16 + j);
      return r;
   endfunction
   task automatic chk_reset(input string tag);
      chk({tag, "_flags"}, {bus.busy, bus.y_valid, bus.x_ready, bus.layer_clr, bus.input_select, bus.mem_layer},
          {5'b00001, 2'd0});
      chk({tag, "_x_out"}, bus.x_out, 0);
      chk({tag, "_y_data"}, bus.y_data, 0);
   endtask
   task automatic send(input vec_t d, input logic [15:0] pat, input int pl, input bit rnd);
      int  i = 0, t = 0;
      bit  v;
      while (i < 4 && t < 200) begin
         v = (t < pl) ? pat[t] : rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         bus.x_valid = v;
         bus.x_data  = v ? d[i] : 16'($urandom);
         if (v && bus.x_ready) begin
            i++;
            h_cyc = cyc + 1;
         end
         @(negedge clk);
         t++;
      end
      bus.x_valid = 1'b0;
      chk("words_accepted", i, 4);
      chk("clr_after_load", bus.layer_clr, 1);
   endtask
   task automatic recv(input vec_t e, input int bpw, input int bpl, input bit rnd);
      int t = 0, j = 0;
      bit r;
      while (!bus.y_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("first_y_valid", bus.y_valid, 1);
      if (!bus.y_valid) return;
      chk("latency", cyc - h_cyc, 36);
      t = 0;
      while (j < 4) begin
         r = (j == bpw && t < bpl) ? 1'b0 : (rnd && t < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.y_ready = r;
         chk("y_data", bus.y_data, e[j]);
         chk("emit_ctrl", {bus.y_valid, bus.busy, bus.input_select, bus.x_ready, bus.layer_clr, bus.mem_layer, bus.x_out},
             {5'b11100, 2'd3, 16'd0});
         @(negedge clk);
         if (r) begin
            j++;
            t = 0;
         end else t++;
      end
      bus.y_ready = 1'b0;
      chk("done_flags", {bus.busy, bus.y_valid, bus.x_ready, bus.mem_layer}, {3'b001, 2'd0});
   endtask
   task automatic run(input vec_t d, input logic [15:0] pat, input int pl, input int bpw, input int bpl, input bit rnd);
      vec_t v = d;
      logic [15:0] ef [16];
      for (int l = 0; l < 4; l++) begin
         for (int j = 0; j < 4; j++) ef[l * 4 + j] = v[j];
         v = layer_fn(v, l);
      end
      feed_q.delete(); feedl_q.delete(); clr_q.delete(); drl_q.delete();
      mon_en = 1'b1;
      send(d, pat, pl, rnd);
      recv(v, bpw, bpl, rnd);
      mon_en = 1'b0;
      chk("clr_count", clr_q.size(), 4);
      for (int l = 0; l < clr_q.size(); l++) chk("clr_layer", clr_q[l], l);
      chk("feed_count", feed_q.size(), 16);
      for (int i = 0; i < feed_q.size(); i++) begin
         chk("feed_word", feed_q[i], ef[i]);
         chk("feed_layer", feedl_q[i], i / 4);
      end
      chk("drain_count", drl_q.size(), 16);
      for (int i = 0; i < drl_q.size(); i++) chk("drain_layer", drl_q[i], i / 4);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      vec_t d;
      int   t;
      bus.x_valid = 1'b0; bus.x_data = '0; bus.y_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("por");
      rst_n = 1'b1;
      #1 chk("x_ready_at_release", bus.x_ready, 0);
      @(negedge clk);
      chk("x_ready_after_release", bus.x_ready, 1);
      d = {16'd40, 16'd30, 16'd20, 16'd10};
      run(d, 16'd0, 0, 4, 0, 1'b0);
      run(d, 16'b1011001, 7, 4, 0, 1'b0);
      d = {16'h0d0d, 16'h0c0c, 16'h0b0b, 16'h0a0a};
      run(d, 16'd0, 0, 2, 5, 1'b0);
      off = 16'h100;
      run(d, 16'd0, 0, 4, 0, 1'b0);
      mode = 1'b1;
      for (int n = 0; n < 16; n++) begin
         for (int j = 0; j < 4; j++) d[j] = 16'($urandom);
         run(d, 16'd0, 0, $urandom_range(0, 3), $urandom_range(0, 6), 1'b1);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      mode = 1'b0; off = '0;
      send(d, 16'd0, 0, 1'b0);
      t = 0;
      while (bus.input_select && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("reached_drain", bus.input_select, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset("mid_drain");
      @(negedge clk);
      chk_reset("held");
      rst_n = 1'b1;
      #1 chk("x_ready_rerelease", bus.x_ready, 0);
      @(negedge clk);
      chk("x_ready_after_rerelease", bus.x_ready, 1);
      mode = 1'b1;
      for (int j = 0; j < 4; j++) d[j] = 16'($urandom);
      run(d, 16'd0, 0, 1, 3, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/inference_sequencer.md
Name: inference_sequencer

Overview:
- Read-side controller for the weight memory and layer datapath: the counterpart to the write-side load sequence that fills memory by (layer, node).
- Accepts one input vector of LAYER_SIZE words over a valid/ready stream.
- For each memory layer address in turn, it drives the layer's clear, input_select and serial x, then captures the layer outputs as the next layer's inputs.
- After LAYER_DEPTH layers it emits the result vector on a valid/ready output stream.

Parameters:
LAYER_SIZE, 4, nodes per layer; words per input and output vector
LAYER_DEPTH, 4, number of layers stored in memory
BIT_SIZE, 16, datapath word width

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-low
x_valid  input  1  input word valid
x_ready  output  1  sequencer can accept an input word
x_data  input  BIT_SIZE  input word
mem_layer  output  $clog2(LAYER_DEPTH)  memory layer read address
layer_clr  output  1  one-cycle clear pulse to the layer datapath
input_select  output  1  1 = layer loads serial x; 0 = layer propagates
x_out  output  BIT_SIZE  serial word to the layer
y_in  input  BIT_SIZE  layer output word
y_valid  output  1  result word valid
y_ready  input  1  downstream accepts the result word
y_data  output  BIT_SIZE  result word
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous), with every value below forced while rst=0:
  - state=IDLE; k=0; mem_layer=0; all buffer entries 0.
  - x_ready=0 (first rises the cycle after reset releases); layer_clr=0; input_select=1; x_out=0; y_valid=0; y_data=0; busy=0.
- Internal state:
  - buf[LAYER_SIZE] of BIT_SIZE words.
  - Word counter k, 0..LAYER_SIZE-1.
  - Layer counter equal to mem_layer.
- States:
  - IDLE:
    - x_ready=1.
    - On x_valid: buf[0]=x_data, k=1, go to LOAD.
    - If LAYER_SIZE=1, go directly to CLEAR.
  - LOAD:
    - x_ready=1.
    - Each x_valid cycle: buf[k]=x_data, k++.
    - When word LAYER_SIZE-1 is accepted: k=0, mem_layer=0, go to CLEAR.
    - Cycles with x_valid=0 stall without change.
  - CLEAR:
    - One cycle; layer_clr=1, input_select=1.
    - mem_layer is held stable from CLEAR through the end of DRAIN, which gives a one-cycle registered memory read time to settle.
  - FEED:
    - LAYER_SIZE cycles; input_select=1, x_out=buf[k], k increments each cycle.
    - At k=LAYER_SIZE-1: k=0, go to DRAIN.
  - DRAIN:
    - LAYER_SIZE cycles; input_select=0, x_out=0.
    - At each rising edge: buf[k]=y_in, k++.
    - On the last word:
      - If mem_layer=LAYER_DEPTH-1: go to EMIT with k=0.
      - Otherwise: mem_layer++ and go to CLEAR.
  - EMIT:
    - y_valid=1, y_data=buf[k].
    - On y_valid&y_ready: k++.
    - On the handshake of the last word: go to IDLE with k=0 and mem_layer=0.
    - y_data is held stable while y_ready=0.
- Timing:
  - Outputs are registered except y_data, which is a mux of buf[k] in EMIT and 0 otherwise.
  - Per-layer cost: 1+2*LAYER_SIZE cycles.
  - Latency from last input handshake to first y_valid: LAYER_DEPTH*(1+2*LAYER_SIZE) cycles, which is 36 at the defaults.
- Boundaries:
  - x_ready=0 outside IDLE and LOAD; x_valid is ignored there.
  - mem_layer never exceeds LAYER_DEPTH-1; no wrap occurs inside an inference.
  - Final EMIT handshake: x_ready=1 on the next cycle. An input arriving then starts a new inference; no back-to-back overlap.
  - Reset asserted mid-inference: immediate return to the reset values; partial buffer contents are discarded.
  - y_ready held low indefinitely: the sequencer stalls in EMIT, and no other output changes.

Test Plan:
1. Reset and idle behaviour:
   - Stimulus: assert rst=0 mid-DRAIN.
   - Required: busy=0, y_valid=0, mem_layer=0 immediately.
   - Required after release: x_ready=1 next cycle.
2. Single inference with a behavioral layer stub:
   - Stub: y_in={mem_layer, k} packed in low bits.
   - Stimulus: inputs 10, 20, 30, 40.
   - Required: first layer-0 FEED emits x_out 10, 20, 30, 40.
   - Required: layer-1 FEED emits 0x00, 0x01, 0x02, 0x03.
   - Required: results are 0x30, 0x31, 0x32, 0x33.
   - Required: first y_valid occurs 36 cycles after the last x handshake.
3. Input stalls:
   - Stimulus: x_valid toggled 1,0,0,1,1,0,1.
   - Required: exactly 4 words are captured in order; CLEAR starts the cycle after the 4th accept.
   - Required: layer_clr is high for exactly one cycle per layer (4 pulses total).
4. Output backpressure:
   - Stimulus: y_ready low for 5 cycles on word 2.
   - Required: y_data stable throughout; all 4 words are delivered in order; busy drops after the 4th handshake.
5. Address sequencing:
   - Required: mem_layer steps 0, 1, 2, 3, constant across each CLEAR/FEED/DRAIN group; returns to 0 in IDLE.
   - Required: input_select=0 for exactly 4 cycles per layer.
6. Back-to-back inferences:
   - Stimulus: x_valid presented on the cycle after the final y handshake.
   - Required: accepted immediately.
   - Required: second results are independent of the first, checked with stub outputs offset by 0x100.
